if_stage: RTL and testbench

//   Instruction-fetch stage and IF/ID pipeline register: the stage directly upstream of control_unit.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with I-cache handshake, skid buffer and IF/ID register.
// Optional jump predecode enabled by defining IF_JUMP_PREDECODE_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic [31:0] icache_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_pred_taken
);
  typedef enum logic [1:0] {REQ, DROP, BUF} state_t;
  state_t      state;
  logic [31:0] fetch_addr, redir_pc, skid_instr, skid_pc, seq_pc, next_pc;
  logic [31:0] load_instr, load_pc;
  logic        skid_pred, hs, jump, load, load_pred;
  assign icache_req  = (state == REQ || state == DROP) && !rst;
  assign icache_addr = fetch_addr;
  assign hs          = icache_req && icache_ready;
  assign seq_pc      = fetch_addr + 32'd4;
`ifdef IF_JUMP_PREDECODE_EN
  assign jump = icache_rdata[31:26] == 6'b000010;
`else
  assign jump = 1'b0;
`endif
  assign next_pc    = jump ? {seq_pc[31:28], icache_rdata[25:0], 2'b00} : seq_pc;
  assign load       = !redirect_valid && !stall && ((state == REQ && hs) || state == BUF);
  assign load_instr = state == BUF ? skid_instr : icache_rdata;
  assign load_pc    = state == BUF ? skid_pc : fetch_addr;
  assign load_pred  = state == BUF ? skid_pred : jump;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= REQ;
      fetch_addr      <= RESET_PC;
      redir_pc        <= RESET_PC;
      skid_instr      <= NOP_INSTR;
      skid_pc         <= '0;
      skid_pred       <= 1'b0;
      ifid_valid      <= 1'b0;
      ifid_instr      <= NOP_INSTR;
      ifid_pc         <= '0;
      ifid_pc4        <= '0;
      ifid_pred_taken <= 1'b0;
    end else begin
      unique case (state)
        REQ:
          if (hs && redirect_valid) fetch_addr <= redirect_pc;
          else if (hs) begin
            fetch_addr <= next_pc;
            if (stall) begin
              skid_instr <= icache_rdata;
              skid_pc    <= fetch_addr;
              skid_pred  <= jump;
              state      <= BUF;
            end
          end else if (redirect_valid) begin
            redir_pc <= redirect_pc;
            state    <= DROP;
          end
        DROP:
          if (hs) begin
            fetch_addr <= redirect_valid ? redirect_pc : redir_pc;
            state      <= REQ;
          end else if (redirect_valid) redir_pc <= redirect_pc;
        BUF:
          if (redirect_valid) begin
            fetch_addr <= redirect_pc;
            state      <= REQ;
          end else if (!stall) state <= REQ;
        default: state <= REQ;
      endcase
      if (flush) begin
        ifid_valid      <= 1'b0;
        ifid_instr      <= NOP_INSTR;
        ifid_pred_taken <= 1'b0;
      end else if (!stall) begin
        ifid_valid      <= load;
        ifid_instr      <= load ? load_instr : NOP_INSTR;
        ifid_pc         <= load ? load_pc : ifid_pc;
        ifid_pc4        <= load ? load_pc + 32'd4 : ifid_pc4;
        ifid_pred_taken <= load && load_pred;
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage.
module tb_if_stage;
  logic        clk = 0, rst = 1, icache_ready = 0, stall = 0, flush = 0, redirect_valid = 0;
  logic [31:0] icache_rdata = 32'h012A4020, redirect_pc = 0;
  logic        icache_req, ifid_valid, ifid_pred_taken;
  logic [31:0] icache_addr, ifid_instr, ifid_pc, ifid_pc4;
  typedef struct {logic [31:0] pc; logic [31:0] instr; logic pred;} ent_t;
  ent_t q[$];
  int checks = 0, errors = 0;
  if_stage dut (
    .clk(clk), .rst(rst), .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .ifid_valid(ifid_valid),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_pred_taken(ifid_pred_taken)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    ent_t e;
    e.pc = pc; e.instr = instr; e.pred = pred;
    q.push_back(e);
  endtask
  task automatic pop_chk(input string tag);
    ent_t e;
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(q.size()), 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, 32'(ifid_valid), 32'd1);
      chk({tag, "_pc"}, ifid_pc, e.pc);
      chk({tag, "_pc4"}, ifid_pc4, e.pc + 32'd4);
      chk({tag, "_instr"}, ifid_instr, e.instr);
      chk({tag, "_pred"}, 32'(ifid_pred_taken), 32'(e.pred));
    end
  endtask
  initial begin
    logic        exp_pred;
    logic [31:0] exp_next;
`ifdef IF_JUMP_PREDECODE_EN
    exp_pred = 1'b1; exp_next = 32'h40;
`else
    exp_pred = 1'b0; exp_next = 32'h24;
`endif
    tick(); tick();
    chk("rst_req", 32'(icache_req), 32'd0);
    rst = 0; #1;
    chk("rst_req_up", 32'(icache_req), 32'd1);
    chk("rst_addr", icache_addr, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pred", 32'(ifid_pred_taken), 32'd0);
    // streaming at one instruction per cycle
    icache_ready = 1;
    push(32'h0, 32'h012A4020, 0); tick(); pop_chk("s0");
    chk("s_addr4", icache_addr, 32'h4);
    push(32'h4, 32'h012A4020, 0); tick(); pop_chk("s4");
    chk("s_addr8", icache_addr, 32'h8);
    // stall rising in the handshake cycle for 0x8
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_pc", ifid_pc, 32'h4);
      chk("st_hold_valid", 32'(ifid_valid), 32'd1);
      chk("st_req", 32'(icache_req), 32'd0);
    end
    stall = 0;
    push(32'h8, 32'h012A4020, 0); tick(); pop_chk("st8");
    chk("st_addrC", icache_addr, 32'hC);
    push(32'hC, 32'h012A4020, 0); tick(); pop_chk("stC");
    // redirect while request pending
    icache_ready = 0; tick();
    chk("rd_bubble", 32'(ifid_valid), 32'd0);
    redirect_valid = 1; flush = 1; redirect_pc = 32'h40; tick();
    redirect_valid = 0; flush = 0;
    for (int i = 0; i < 3; i++) begin
      chk("rd_addr_hold", icache_addr, 32'h10);
      chk("rd_req_hold", 32'(icache_req), 32'd1);
      chk("rd_valid0", 32'(ifid_valid), 32'd0);
      if (i < 2) tick();
    end
    icache_ready = 1; tick();
    chk("rd_addr40", icache_addr, 32'h40);
    chk("rd_dropped", 32'(ifid_valid), 32'd0);
    push(32'h40, 32'h012A4020, 0); tick(); pop_chk("rd40");
    // flush beats stall
    icache_ready = 0; flush = 1; stall = 1; tick();
    flush = 0; stall = 0;
    chk("fl_valid", 32'(ifid_valid), 32'd0);
    chk("fl_instr", ifid_instr, 32'h0);
    chk("fl_addr", icache_addr, 32'h44);
    // jump predecode at 0x20
    icache_ready = 1; redirect_valid = 1; redirect_pc = 32'h20; tick();
    redirect_valid = 0;
    chk("j_addr20", icache_addr, 32'h20);
    chk("j_drop_valid", 32'(ifid_valid), 32'd0);
    icache_rdata = 32'h08000010;
    push(32'h20, 32'h08000010, exp_pred); tick(); pop_chk("j20");
    chk("j_next", icache_addr, exp_next);
    // PC wrap at the top of the address space
    icache_rdata = 32'h012A4020; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick();
    redirect_valid = 0;
    chk("w_addr", icache_addr, 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'h012A4020, 0); tick(); pop_chk("wrap");
    chk("w_addr0", icache_addr, 32'h0);
    // reset mid-request
    icache_ready = 0; tick();
    rst = 1; #1;
    chk("mr_req", 32'(icache_req), 32'd0);
    tick();
    rst = 0; #1;
    chk("mr_addr", icache_addr, 32'h0);
    chk("mr_valid", 32'(ifid_valid), 32'd0);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
